sipo_stream: RTL and testbench

SIPO_STREAM -- requirements
Module: sipo_stream

---
 rtl/sipo_stream_pkg.sv | 13 +
 rtl/sipo_stream_if.sv | 24 ++
 rtl/sipo_stream.sv | 137 +++++++++++++
 tb/tb_sipo_stream.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sipo_stream_pkg.sv
// Shared types and constants for the sipo_stream serial-to-parallel deserialiser.
// Optional parity support is enabled with the SIPO_STREAM_PARITY_EN macro.
package sipo_stream_pkg;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_e;

  localparam DIR_MSB_FIRST = "msb_first";
  localparam DIR_LSB_FIRST = "lsb_first";

endpackage : sipo_stream_pkg

// File: rtl/sipo_stream_if.sv
// Serial input / parallel stream output bundle for sipo_stream.
// master is the deserialiser side; slave is the serial source plus the word sink.
interface sipo_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic                  data;
  logic                  sync;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  ovf;
  logic                  par_err;

  modport master (
    input  en, data, sync, m_ready,
    output m_data, m_valid, ovf, par_err
  );

  modport slave (
    output en, data, sync, m_ready,
    input  m_data, m_valid, ovf, par_err
  );
endinterface : sipo_stream_if

// File: rtl/sipo_stream.sv
// Serial-in parallel-out deserialiser with a valid/ready word output and overflow pulse.
// Define SIPO_STREAM_PARITY_EN to append a parity bit to each frame and flag errors.
module sipo_stream
  import sipo_stream_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter       DIRECTION  = DIR_MSB_FIRST,
  parameter logic PARITY_ODD = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  a_rst_n_i,
  input  logic                  en_i,
  input  logic                  data_i,
  input  logic                  sync_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  ovf_o,
  output logic                  par_err_o
);

  localparam int CW        = $clog2(DATA_WIDTH);
  localparam bit MSB_FIRST = (DIRECTION == DIR_MSB_FIRST);

  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_base, shift_in;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_base;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d, word;
  logic                  m_valid_q, m_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  par_err_q, par_err_d, par_calc;
  logic                  last_bit, complete;

`ifdef SIPO_STREAM_PARITY_EN
  state_e state_q, state_d, state_base;
`endif

  // sync_i restarts the frame first, so a bit accepted alongside it becomes bit 0.
  assign shift_base = sync_i ? '0 : shift_q;
  assign cnt_base   = sync_i ? '0 : cnt_q;
  assign shift_in   = MSB_FIRST ? {shift_base[DATA_WIDTH-2:0], data_i}
                                : {data_i, shift_base[DATA_WIDTH-1:1]};
  assign last_bit   = (cnt_base == CW'(DATA_WIDTH - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    shift_d  = shift_base;
    cnt_d    = cnt_base;
    complete = 1'b0;
    word     = shift_in;
    par_calc = 1'b0;
`ifdef SIPO_STREAM_PARITY_EN
    state_base = sync_i ? S_DATA : state_q;
    state_d    = state_base;
    if (en_i) begin
      case (state_base)
        S_DATA: begin
          shift_d = shift_in;
          if (last_bit) begin
            cnt_d   = '0;
            state_d = S_PAR;
          end else begin
            cnt_d = cnt_base + CW'(1);
          end
        end
        S_PAR: begin
          // The parity bit completes the word held in the shift register.
          complete = 1'b1;
          word     = shift_q;
          par_calc = ((^shift_q) ^ data_i) != PARITY_ODD;
          state_d  = S_DATA;
        end
        default: state_d = S_DATA;
      endcase
    end
`else
    if (en_i) begin
      shift_d  = shift_in;
      cnt_d    = last_bit ? '0 : cnt_base + CW'(1);
      complete = last_bit;
    end
`endif
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q & ~m_ready_i;
    par_err_d = par_err_q;
    ovf_d     = 1'b0;
    if (complete) begin
      if (!m_valid_q || m_ready_i) begin
        m_data_d  = word;
        m_valid_d = 1'b1;
        par_err_d = par_calc;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      par_err_q <= 1'b0;
`ifdef SIPO_STREAM_PARITY_EN
      state_q   <= S_DATA;
`endif
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      ovf_q     <= ovf_d;
      par_err_q <= par_err_d;
`ifdef SIPO_STREAM_PARITY_EN
      state_q   <= state_d;
`endif
    end
  end

  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign ovf_o     = ovf_q;

`ifdef SIPO_STREAM_PARITY_EN
  assign par_err_o = par_err_q;
`else
  logic unused_par;
  assign unused_par = PARITY_ODD ^ par_err_q;
  assign par_err_o  = 1'b0;
`endif

endmodule : sipo_stream

// File: tb/tb_sipo_stream.sv
// Directed self-checking bench for sipo_stream: an msb_first and an lsb_first instance
// share one stimulus stream; parity checks run when SIPO_STREAM_PARITY_EN is defined.
module tb_sipo_stream;
  import sipo_stream_pkg::*;

  localparam int W = 8;
`ifdef SIPO_STREAM_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sipo_stream_if #(.DATA_WIDTH(W)) bm ();
  sipo_stream_if #(.DATA_WIDTH(W)) bl ();

  assign bl.en      = bm.en;
  assign bl.data    = bm.data;
  assign bl.sync    = bm.sync;
  assign bl.m_ready = bm.m_ready;

  sipo_stream #(.DATA_WIDTH(W), .DIRECTION(DIR_MSB_FIRST), .PARITY_ODD(1'b0)) dut_msb (
    .clk_i(clk), .a_rst_n_i(rst_n), .en_i(bm.en), .data_i(bm.data), .sync_i(bm.sync),
    .m_data_o(bm.m_data), .m_valid_o(bm.m_valid), .m_ready_i(bm.m_ready),
    .ovf_o(bm.ovf), .par_err_o(bm.par_err)
  );

  sipo_stream #(.DATA_WIDTH(W), .DIRECTION(DIR_LSB_FIRST), .PARITY_ODD(1'b0)) dut_lsb (
    .clk_i(clk), .a_rst_n_i(rst_n), .en_i(bl.en), .data_i(bl.data), .sync_i(bl.sync),
    .m_data_o(bl.m_data), .m_valid_o(bl.m_valid), .m_ready_i(bl.m_ready),
    .ovf_o(bl.ovf), .par_err_o(bl.par_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bm.en   = 1'b1;
    bm.data = b;
    tick();
    bm.en   = 1'b0;
  endtask

  // Even parity bit that makes the frame error-free.
  function automatic logic good_par(input logic [7:0] w);
    return ^w;
  endfunction

  task automatic send_word(input logic [7:0] w, input logic p);
    for (int i = 0; i < W; i++) drive_bit(w[7-i]);
`ifdef SIPO_STREAM_PARITY_EN
    drive_bit(p);
`else
    if (p === 1'bx) $display("unexpected parity stimulus");
`endif
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    bm.en = 1'b0; bm.data = 1'b0; bm.sync = 1'b0; bm.m_ready = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_data",   bm.m_data,  8'h00);
    check("rst_valid",  bm.m_valid, 1'b0);
    check("rst_ovf",    bm.ovf,     1'b0);
    check("rst_parerr", bm.par_err, 1'b0);
    #6 rst_n = 1'b1;

    // msb_first with two-cycle en gaps: 1,0,1,1,0,0,1,0 -> B2
    v = 8'hB2;
    for (int i = 0; i < W; i++) begin
      drive_bit(v[7-i]);
      if (i != W - 1) begin tick(); tick(); end
    end
`ifdef SIPO_STREAM_PARITY_EN
    drive_bit(good_par(8'hB2));
`endif
    check("gap_data",   bm.m_data,  8'hB2);
    check("gap_valid",  bm.m_valid, 1'b1);
    check("gap_parerr", bm.par_err, 1'b0);
    tick();
    check("gap_valid_drop", bm.m_valid, 1'b0);

    // lsb_first, continuous: same bit sequence -> 4D, then FF with no gap
    send_word(8'hB2, good_par(8'hB2));
    check("lsb_data",  bl.m_data,  8'h4D);
    check("lsb_valid", bl.m_valid, 1'b1);
    check("msb_b2b",   bm.m_data,  8'hB2);
    for (int i = 0; i < FRAME; i++) begin
      drive_bit((i < W) ? 1'b1 : good_par(8'hFF));
      if (i == 0)         check("lsb_xfer",     bl.m_valid, 1'b0);
      if (i == FRAME - 2) check("lsb_not_yet",  bl.m_valid, 1'b0);
    end
    check("lsb_ff_data",  bl.m_data,  8'hFF);
    check("lsb_ff_valid", bl.m_valid, 1'b1);
    check("msb_ff_data",  bm.m_data,  8'hFF);
    tick();

    // Overflow: sink stalled, second word dropped
    bm.m_ready = 1'b0;
    send_word(8'hA5, good_par(8'hA5));
    check("ovf_first_data",  bm.m_data,  8'hA5);
    check("ovf_first_valid", bm.m_valid, 1'b1);
    check("ovf_first_pulse", bm.ovf,     1'b0);
    send_word(8'h3C, good_par(8'h3C));
    check("ovf_hold_data",  bm.m_data,  8'hA5);
    check("ovf_hold_valid", bm.m_valid, 1'b1);
    check("ovf_pulse",      bm.ovf,     1'b1);
    tick();
    check("ovf_pulse_end",  bm.ovf,     1'b0);
    check("ovf_still_a5",   bm.m_data,  8'hA5);
    bm.m_ready = 1'b1;
    tick();
    check("ovf_drain_valid", bm.m_valid, 1'b0);

    // sync with en restarts the frame; data bit taken as bit 0 of 5A
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    v = 8'h5A;
    bm.en = 1'b1; bm.sync = 1'b1; bm.data = v[7];
    tick();
    bm.en = 1'b0; bm.sync = 1'b0;
    check("sync_no_word", bm.m_valid, 1'b0);
    for (int i = 6; i >= 0; i--) drive_bit(v[i]);
`ifdef SIPO_STREAM_PARITY_EN
    drive_bit(good_par(8'h5A));
`endif
    check("sync_data",  bm.m_data,  8'h5A);
    check("sync_valid", bm.m_valid, 1'b1);
    check("sync_ovf",   bm.ovf,     1'b0);
    tick();

    // Asynchronous reset mid-frame, no clock edge while low
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_data",  bm.m_data,  8'h00);
    check("arst_valid", bm.m_valid, 1'b0);
    rst_n = 1'b1;
    send_word(8'hC3, good_par(8'hC3));
    check("arst_c3_data",  bm.m_data,  8'hC3);
    check("arst_c3_valid", bm.m_valid, 1'b1);
    tick();

`ifdef SIPO_STREAM_PARITY_EN
    send_word(8'hA5, 1'b0);
    check("par_ok_data", bm.m_data,  8'hA5);
    check("par_ok",      bm.par_err, 1'b0);
    tick();
    send_word(8'hA5, 1'b1);
    check("par_bad_data", bm.m_data,  8'hA5);
    check("par_bad",      bm.par_err, 1'b1);
    tick();
`else
    check("par_tied_msb", bm.par_err, 1'b0);
    check("par_tied_lsb", bl.par_err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sipo_stream
